// File: rtl/alu_mul_pipe_if.sv
// Request/response bundle for the pipelined multiplier: request side with flush,
// result side with backpressure, plus an occupancy flag.
interface alu_mul_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       alu_control;
    logic [XLEN-1:0]  op1_data;
    logic [XLEN-1:0]  op2_data;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  alu_output;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, alu_control, op1_data, op2_data, in_tag, flush, out_ready,
        input  in_ready, out_valid, alu_output, out_tag, busy
    );

    modport slave (
        input  in_valid, alu_control, op1_data, op2_data, in_tag, flush, out_ready,
        output in_ready, out_valid, alu_output, out_tag, busy
    );
endinterface

// File: rtl/alu_mul_pipe.sv
// STAGES-deep multiplier pipeline for MUL/MULH/MULHSU/MULHU/MULW with tag
// tracking, flush, and a single global stall driven by output backpressure.
module alu_mul_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic         clk,
    input  logic         rst,
    alu_mul_pipe_if.slave bus
);
    localparam logic [4:0] OP_MUL    = 5'd12;
    localparam logic [4:0] OP_MULH   = 5'd13;
    localparam logic [4:0] OP_MULHSU = 5'd14;
    localparam logic [4:0] OP_MULHU  = 5'd15;
    localparam logic [4:0] OP_MULW   = 5'd16;

    function automatic logic is_mul(input logic [4:0] code);
        case (code)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: is_mul = 1'b1;
            OP_MULW:                              is_mul = (XLEN == 64);
            default:                              is_mul = 1'b0;
        endcase
    endfunction

    // MULW only needs the low 32 product bits, which do not depend on operand signedness.
    function automatic logic [XLEN-1:0] sel_result(input logic [4:0] code,
                                                   input logic [2*XLEN-1:0] prod);
        logic [XLEN-1:0] res;
        res = '0;
        case (code)
            OP_MUL: res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
            OP_MULW: begin
                res[31:0] = prod[31:0];
                for (int i = 32; i < XLEN; i++) res[i] = prod[31];
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    logic                    w_adv;
    logic                    w_op1_signed;
    logic                    w_op2_signed;
    logic signed [XLEN:0]    w_op1_ext;
    logic signed [XLEN:0]    w_op2_ext;
    logic signed [2*XLEN-1:0] w_prod;

    logic                    r_vld_p  [STAGES];
    logic [2*XLEN-1:0]       r_prod_p [STAGES];
    logic [4:0]              r_code_p [STAGES];
    logic [TAG_W-1:0]        r_tag_p  [STAGES];

    assign w_adv = !(r_vld_p[STAGES-1] && !bus.out_ready);

    assign w_op1_signed = (bus.alu_control == OP_MUL) || (bus.alu_control == OP_MULH) ||
                          (bus.alu_control == OP_MULHSU);
    assign w_op2_signed = (bus.alu_control == OP_MUL) || (bus.alu_control == OP_MULH);
    assign w_op1_ext = signed'({w_op1_signed & bus.op1_data[XLEN-1], bus.op1_data});
    assign w_op2_ext = signed'({w_op2_signed & bus.op2_data[XLEN-1], bus.op2_data});
    assign w_prod    = (2*XLEN)'(w_op1_ext) * (2*XLEN)'(w_op2_ext);

    // Stage boundary: operation enters p0, then shifts toward the output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) r_vld_p[i] <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < STAGES; i++) r_vld_p[i] <= 1'b0;
        end else if (w_adv) begin
            r_vld_p[0] <= bus.in_valid && is_mul(bus.alu_control);
            for (int i = 1; i < STAGES; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_prod_p[0] <= w_prod;
            r_code_p[0] <= bus.alu_control;
            r_tag_p[0]  <= bus.in_tag;
            for (int i = 1; i < STAGES; i++) begin
                r_prod_p[i] <= r_prod_p[i-1];
                r_code_p[i] <= r_code_p[i-1];
                r_tag_p[i]  <= r_tag_p[i-1];
            end
        end
    end

    // Output stage: result selection from the carried code, zeroed when idle.
    assign bus.in_ready   = w_adv;
    assign bus.out_valid  = r_vld_p[STAGES-1];
    assign bus.alu_output = r_vld_p[STAGES-1] ?
                            sel_result(r_code_p[STAGES-1], r_prod_p[STAGES-1]) : '0;
    assign bus.out_tag    = r_vld_p[STAGES-1] ? r_tag_p[STAGES-1] : '0;

    always_comb begin
        bus.busy = 1'b0;
        for (int i = 0; i < STAGES; i++) bus.busy = bus.busy | r_vld_p[i];
    end
endmodule

// File: tb/tb_alu_mul_pipe.sv
// Scoreboard bench for alu_mul_pipe (XLEN=64, STAGES=2): table vectors,
// random traffic with backpressure, and stall/flush/reset sequences.
module tb_alu_mul_pipe;
    localparam int XLEN = 64;
    localparam int STG  = 2;
    localparam int TW   = 5;

    typedef struct {
        logic [4:0]  code;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        bit          legal;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  tag;
        logic [63:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_pop  = 0;
    exp_t sb[$];

    alu_mul_pipe_if #(.XLEN(XLEN), .TAG_W(TW)) bus ();

    alu_mul_pipe #(.XLEN(XLEN), .STAGES(STG), .TAG_W(TW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model(input logic [4:0] code, input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [129:0] ea, eb, p;
        bit s1, s2;
        s1 = (code == 5'd12) || (code == 5'd13) || (code == 5'd14);
        s2 = (code == 5'd12) || (code == 5'd13);
        ea = {{66{a[63] & s1}}, a};
        eb = {{66{b[63] & s2}}, b};
        p  = ea * eb;
        case (code)
            5'd12:             return a * b;
            5'd13, 5'd14, 5'd15: return p[127:64];
            5'd16:             return {{32{p[31]}}, p[31:0]};
            default:           return 64'd0;
        endcase
    endfunction

    // Monitor: consume results, check order/values, idle zeros and stall stability.
    bit          prev_stall = 0;
    logic [63:0] prev_out;
    logic [4:0]  prev_tag;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 64'(bus.out_valid), 64'd1);
                check("stall_hold_data", bus.alu_output, prev_out);
                check("stall_hold_tag", 64'(bus.out_tag), 64'(prev_tag));
            end
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result_tag", 64'(bus.out_tag), 64'h1_0000_0000);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        n_pop++;
                        check("result_tag", 64'(bus.out_tag), 64'(e.tag));
                        check("result_data", bus.alu_output, e.res);
                    end
                end
            end else begin
                check("idle_output_zero", bus.alu_output, 64'd0);
                check("idle_tag_zero", 64'(bus.out_tag), 64'd0);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = bus.alu_output;
            prev_tag   = bus.out_tag;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [4:0] code, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input bit push, input logic [63:0] exp);
        bit acc;
        bus.in_valid    = 1'b1;
        bus.alu_control = code;
        bus.op1_data    = a;
        bus.op2_data    = b;
        bus.in_tag      = tag;
        acc = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        else if (push) sb.push_back('{tag: tag, res: exp});
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() > 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    vec_t tbl[14];
    int   lat;
    int   pops0;

    initial begin
        bus.in_valid = 0; bus.alu_control = 0; bus.op1_data = 0; bus.op2_data = 0;
        bus.in_tag = 0; bus.flush = 0; bus.out_ready = 1;

        tbl[0]  = '{5'd12, -64'sd3, 64'd7, 5'd4, 1'b1, 64'hFFFFFFFFFFFFFFEB};
        tbl[1]  = '{5'd13, 64'h8000000000000000, 64'h8000000000000000, 5'd5, 1'b1, 64'h4000000000000000};
        tbl[2]  = '{5'd15, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd6, 1'b1, 64'hFFFFFFFFFFFFFFFE};
        tbl[3]  = '{5'd14, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd7, 1'b1, 64'hFFFFFFFFFFFFFFFF};
        tbl[4]  = '{5'd16, 64'h0000000100010000, 64'h8000, 5'd8, 1'b1, 64'hFFFFFFFF80000000};
        tbl[5]  = '{5'd12, 64'h123456789, 64'h1000, 5'd9, 1'b1, 64'h0000123456789000};
        tbl[6]  = '{5'd15, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd10, 1'b1, 64'd1};
        tbl[7]  = '{5'd13, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd11, 1'b1, 64'd0};
        tbl[8]  = '{5'd14, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd12, 1'b1, 64'h8000000000000000};
        tbl[9]  = '{5'd5, 64'd3, 64'd3, 5'd13, 1'b0, 64'd0};
        tbl[10] = '{5'd13, 64'd2, 64'd3, 5'd14, 1'b1, 64'd0};
        tbl[11] = '{5'd16, 64'h7FFFFFFF, 64'd2, 5'd15, 1'b1, 64'hFFFFFFFFFFFFFFFE};
        tbl[12] = '{5'd0, 64'd5, 64'd6, 5'd16, 1'b0, 64'd0};
        tbl[13] = '{5'd17, 64'd5, 64'd6, 5'd17, 1'b0, 64'd0};

        // Reset state, held asynchronously.
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_data", bus.alu_output, 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // First-result latency for the basic MUL vector.
        issue(tbl[0].code, tbl[0].a, tbl[0].b, tbl[0].tag, 1'b1, tbl[0].exp);
        lat = 1;
        for (int k = 0; k < 10 && !bus.out_valid; k++) begin
            @(posedge clk); #1; lat++;
        end
        check("latency_cycles", 64'(lat), 64'(STG));
        check("latency_tag", 64'(bus.out_tag), 64'd4);
        drain();

        // Table vectors back-to-back.
        for (int i = 0; i < 14; i++)
            issue(tbl[i].code, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].legal, tbl[i].exp);
        drain();

        // Four back-to-back with a 3-cycle stall once the first result shows.
        fork
            begin
                for (int t = 1; t <= 4; t++)
                    issue(5'd12, 64'(t), 64'd3, 5'(t), 1'b1, 64'(3 * t));
            end
            begin
                bit seen;
                seen = 0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(posedge clk); #1;
                    seen = bus.out_valid;
                end
                check("stall_first_seen", 64'(seen), 64'd1);
                bus.out_ready = 0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    check("stall_out_tag", 64'(bus.out_tag), 64'd1);
                end
                @(posedge clk); #1;
                bus.out_ready = 1;
                for (int t = 1; t <= 4; t++) begin
                    @(negedge clk);
                    check("release_valid", 64'(bus.out_valid), 64'd1);
                    check("release_tag", 64'(bus.out_tag), 64'(t));
                end
            end
        join
        drain();

        // Illegal code between two MULs yields exactly two results.
        pops0 = n_pop;
        issue(5'd12, 64'd6, 64'd7, 5'd20, 1'b1, 64'd42);
        issue(5'd5, 64'd6, 64'd7, 5'd21, 1'b0, 64'd0);
        issue(5'd12, 64'd8, 64'd9, 5'd22, 1'b1, 64'd72);
        drain();
        check("illegal_result_count", 64'(n_pop - pops0), 64'd2);

        // Flush: one op in flight, flush with another accepted the same cycle.
        bus.in_valid = 1; bus.alu_control = 5'd12; bus.op1_data = 64'd2;
        bus.op2_data = 64'd2; bus.in_tag = 5'd25;
        @(posedge clk); #1;
        bus.in_tag = 5'd26; bus.flush = 1;
        @(posedge clk); #1;
        bus.in_valid = 0; bus.flush = 0;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_busy", 64'(bus.busy), 64'd0);
        repeat (6) @(posedge clk);
        #1;

        // Reset with an op in the middle stage: nothing ever emerges.
        issue(5'd13, 64'd9, 64'd9, 5'd27, 1'b0, 64'd0);
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        #1 rst = 1;
        #1;
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1 rst = 0;
        repeat (5) @(posedge clk);
        #1;

        // Reset while a result is presented clears the output without a clock edge.
        issue(5'd12, 64'd5, 64'd5, 5'd28, 1'b0, 64'd0);
        @(posedge clk); #1;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        rst = 1;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_out_data", bus.alu_output, 64'd0);
        @(posedge clk); #1 rst = 0;
        repeat (4) @(posedge clk);
        #1;

        // Random traffic under random backpressure.
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [4:0]  c;
                    logic [63:0] a, b;
                    c = 5'($urandom_range(12, 16));
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    if (i % 4 == 0) a = -64'sd1 - 64'(i);
                    issue(c, a, b, 5'(i), 1'b1, model(c, a, b));
                end
            end
            begin
                repeat (60) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1;
            end
        join
        bus.out_ready = 1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
